// File: rtl/jtpopeye_inputs_if.sv
`timescale 1ns/1ps
// Bus bundle between the platform I/O layer and the Popeye cabinet input conditioner.
// The master drives the raw inputs; the slave returns the game-facing controls.
interface jtpopeye_inputs_if;
    logic [10:0] ps2_key;
    logic [15:0] joy_0;
    logic [15:0] joy_1;
    logic        pause_clr;
    logic [4:0]  joystick1;
    logic [4:0]  joystick2;
    logic [1:0]  start_button;
    logic        coin_input;
    logic        pause;

    modport master (
        output ps2_key, joy_0, joy_1, pause_clr,
        input  joystick1, joystick2, start_button, coin_input, pause
    );

    modport slave (
        input  ps2_key, joy_0, joy_1, pause_clr,
        output joystick1, joystick2, start_button, coin_input, pause
    );
endinterface

// File: rtl/jtpopeye_inputs.sv
`timescale 1ns/1ps
// Cabinet input conditioner for jtpopeye_game: keyboard decode, pad merge, per-channel
// debounce, opposing-direction resolution, coin pulse stretching and the pause latch.
module jtpopeye_inputs #(
    parameter int DEB_CNT     = 40000,
    parameter int COIN_CYCLES = 800000
) (
    input  logic             clk,
    input  logic             rst_n,
    jtpopeye_inputs_if.slave bus
);
    localparam int NCH = 14;
    localparam int DW  = $clog2(DEB_CNT + 1);
    localparam int CW  = $clog2(COIN_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CNT - 1);
    // The edge cycle itself supplies one clock of low time, so the counter holds the rest.
    localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_CYCLES - 1);

    localparam int CH_COIN  = 7;
    localparam int CH_PAUSE = 8;

    logic            r_kbd_tog;
    logic            r_kbd_armed;
    logic [8:0]      r_kbd;
    logic [4:0]      w_kbd_map;
    logic            w_kbd_hit;
    logic [3:0]      w_kbd_idx;
    logic            w_kbd_evt;

    logic [8:0]      w_joy1;
    logic [NCH-1:0]  w_raw;
    logic [NCH-1:0]  r_deb;
    logic [DW-1:0]   r_cnt [NCH];

    logic [4:0]      w_p1;
    logic [4:0]      w_p2;
    logic [4:0]      r_joy1;
    logic [4:0]      r_joy2;
    logic [1:0]      r_start;

    logic            r_coin_prev;
    logic            w_coin_rise;
    logic [CW-1:0]   r_coin_cnt;
    logic            r_coin_n;

    logic            r_pause_prev;
    logic            w_pause_rise;
    logic            r_pause;

    logic            w_unused;

    // Scan code to player-1 channel index: {hit, index}; channels follow the pad bit order.
    function automatic logic [4:0] kbd_map(input logic [7:0] code);
        case (code)
            8'h74:   kbd_map = {1'b1, 4'd0};
            8'h6B:   kbd_map = {1'b1, 4'd1};
            8'h72:   kbd_map = {1'b1, 4'd2};
            8'h75:   kbd_map = {1'b1, 4'd3};
            8'h14:   kbd_map = {1'b1, 4'd4};
            8'h05:   kbd_map = {1'b1, 4'd5};
            8'h06:   kbd_map = {1'b1, 4'd6};
            8'h04:   kbd_map = {1'b1, 4'd7};
            8'h0C:   kbd_map = {1'b1, 4'd8};
            default: kbd_map = {1'b0, 4'd0};
        endcase
    endfunction

    assign w_kbd_map = kbd_map(bus.ps2_key[7:0]);
    assign w_kbd_hit = w_kbd_map[4];
    assign w_kbd_idx = w_kbd_map[3:0];
    // Arming stops a toggle bit left high across reset from replaying a stale event.
    assign w_kbd_evt = r_kbd_armed & (bus.ps2_key[10] ^ r_kbd_tog);

    // Keyboard event detection and make/break latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kbd_tog   <= 1'b0;
            r_kbd_armed <= 1'b0;
            r_kbd       <= 9'd0;
        end else begin
            r_kbd_tog   <= bus.ps2_key[10];
            r_kbd_armed <= 1'b1;
            if (w_kbd_evt && w_kbd_hit) begin
                r_kbd[w_kbd_idx] <= bus.ps2_key[9];
            end
        end
    end

    // Channels 0..8: P1 R,L,D,U,punch,start1,start2,coin,pause; 9..13: P2 R,L,D,U,punch.
    assign w_joy1 = {bus.joy_0[9:6], bus.joy_0[4:0]};
    assign w_raw  = {bus.joy_1[4:0], r_kbd | w_joy1};

    // Per-channel debounce: a change must persist DEB_CNT clocks to be accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb <= {NCH{1'b0}};
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= {DW{1'b0}};
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_raw[i] == r_deb[i]) begin
                    r_cnt[i] <= {DW{1'b0}};
                end else if (r_cnt[i] == DEB_LAST) begin
                    r_deb[i] <= w_raw[i];
                    r_cnt[i] <= {DW{1'b0}};
                end else begin
                    r_cnt[i] <= r_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Opposing directions cancel each other; punch passes through.
    assign w_p1 = {r_deb[4],
                   r_deb[3] & ~r_deb[2], r_deb[2] & ~r_deb[3],
                   r_deb[1] & ~r_deb[0], r_deb[0] & ~r_deb[1]};
    assign w_p2 = {r_deb[13],
                   r_deb[12] & ~r_deb[11], r_deb[11] & ~r_deb[12],
                   r_deb[10] & ~r_deb[9],  r_deb[9]  & ~r_deb[10]};

    // Active-low registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_joy1  <= 5'h1F;
            r_joy2  <= 5'h1F;
            r_start <= 2'b11;
        end else begin
            r_joy1  <= ~w_p1;
            r_joy2  <= ~w_p2;
            r_start <= ~{r_deb[6], r_deb[5]};
        end
    end

    assign w_coin_rise = r_deb[CH_COIN] & ~r_coin_prev;

    // Coin stretcher: low for at least COIN_CYCLES, or for as long as coin is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coin_prev <= 1'b0;
            r_coin_cnt  <= {CW{1'b0}};
            r_coin_n    <= 1'b1;
        end else begin
            r_coin_prev <= r_deb[CH_COIN];
            if (w_coin_rise) begin
                r_coin_cnt <= COIN_LOAD;
            end else if (r_coin_cnt != {CW{1'b0}}) begin
                r_coin_cnt <= r_coin_cnt - CW'(1);
            end else begin
                r_coin_cnt <= {CW{1'b0}};
            end
            r_coin_n <= ~(w_coin_rise | (r_coin_cnt != {CW{1'b0}}) | r_deb[CH_COIN]);
        end
    end

    assign w_pause_rise = r_deb[CH_PAUSE] & ~r_pause_prev;

    // Pause toggle latch; the clear wins over a same-cycle toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pause_prev <= 1'b0;
            r_pause      <= 1'b0;
        end else begin
            r_pause_prev <= r_deb[CH_PAUSE];
            if (bus.pause_clr) begin
                r_pause <= 1'b0;
            end else if (w_pause_rise) begin
                r_pause <= ~r_pause;
            end else begin
                r_pause <= r_pause;
            end
        end
    end

    assign bus.joystick1    = r_joy1;
    assign bus.joystick2    = r_joy2;
    assign bus.start_button = r_start;
    assign bus.coin_input   = r_coin_n;
    assign bus.pause        = r_pause;

    assign w_unused = ^{bus.joy_0[15:10], bus.joy_0[5], bus.joy_1[15:5], bus.ps2_key[8]};
endmodule

// File: tb/tb_jtpopeye_inputs.sv
`timescale 1ns/1ps
// Directed bench for jtpopeye_inputs with DEB_CNT = 8 and COIN_CYCLES = 100;
// expected values are hand-derived from the latency rules of the block.
module tb_jtpopeye_inputs;
    localparam logic [13:0] IDLE = {5'h1F, 5'h1F, 2'b11, 1'b1, 1'b0};

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    logic kbd_tog;
    int   fall_t;
    int   rise_t;

    jtpopeye_inputs_if bus ();

    jtpopeye_inputs #(
        .DEB_CNT     (8),
        .COIN_CYCLES (100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic kbd_event(input logic pressed, input logic [7:0] code);
        kbd_tog = ~kbd_tog;
        bus.ps2_key = {kbd_tog, pressed, 1'b0, code};
    endtask

    function automatic logic [13:0] outs();
        return {bus.joystick1, bus.joystick2, bus.start_button, bus.coin_input, bus.pause};
    endfunction

    // Raise coin for 10 clocks (and again at second_at when nonzero), measure the low window.
    task automatic coin_run(input int second_at, output int f_t, output int r_t);
        logic b;
        f_t = -1;
        r_t = -1;
        bus.joy_0 = 16'h0100;
        for (int t = 1; t <= 300; t++) begin
            tick();
            b = (t < 10) || (second_at > 0 && t >= second_at && t < second_at + 10);
            bus.joy_0 = {7'd0, b, 8'd0};
            if (f_t < 0 && bus.coin_input == 1'b0) f_t = t;
            else if (f_t >= 0 && r_t < 0 && bus.coin_input == 1'b1) r_t = t;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        kbd_tog = 1'b0;
        rst_n = 1'b0;
        bus.ps2_key = 11'd0;
        bus.joy_0 = 16'd0;
        bus.joy_1 = 16'd0;
        bus.pause_clr = 1'b0;
        ticks(3);
        chk("reset_outs", 32'(outs()), 32'(IDLE));
        rst_n = 1'b1;

        for (int i = 0; i < 10000; i++) begin
            tick();
            chk("idle_stable", 32'(outs()), 32'(IDLE));
        end

        // keyboard up: 1 decode + 8 debounce + 1 output
        kbd_event(1'b1, 8'h75);
        ticks(9);
        chk("kbd_up_early", 32'(bus.joystick1), 32'h1F);
        tick();
        chk("kbd_up", 32'(bus.joystick1), 32'h17);
        kbd_event(1'b0, 8'h75);
        ticks(9);
        chk("kbd_up_rel_early", 32'(bus.joystick1), 32'h17);
        tick();
        chk("kbd_up_rel", 32'(bus.joystick1), 32'h1F);

        kbd_event(1'b1, 8'h1C);
        ticks(12);
        chk("kbd_ignored", 32'(outs()), 32'(IDLE));
        kbd_event(1'b0, 8'h1C);
        ticks(2);

        kbd_event(1'b1, 8'h05);
        ticks(10);
        chk("kbd_start1", 32'(bus.start_button), 32'h2);
        kbd_event(1'b0, 8'h05);
        ticks(10);
        chk("kbd_start1_rel", 32'(bus.start_button), 32'h3);

        // short pulse is filtered
        bus.joy_0 = 16'h0001;
        ticks(5);
        bus.joy_0 = 16'h0000;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("glitch_5clk", 32'(bus.joystick1), 32'h1F);
        end

        bus.joy_0 = 16'h0001;
        ticks(8);
        chk("right_early", 32'(bus.joystick1), 32'h1F);
        tick();
        chk("right_on", 32'(bus.joystick1), 32'h1E);
        ticks(11);
        bus.joy_0 = 16'h0000;
        ticks(8);
        chk("right_rel_early", 32'(bus.joystick1), 32'h1E);
        tick();
        chk("right_off", 32'(bus.joystick1), 32'h1F);

        // one-clock drop restarts the count
        bus.joy_0 = 16'h0002;
        ticks(7);
        bus.joy_0 = 16'h0000;
        tick();
        bus.joy_0 = 16'h0002;
        ticks(8);
        chk("restart_early", 32'(bus.joystick1), 32'h1F);
        tick();
        chk("restart_on", 32'(bus.joystick1), 32'h1D);
        bus.joy_0 = 16'h0000;
        ticks(10);

        // keyboard left against pad right cancels
        kbd_event(1'b1, 8'h6B);
        bus.joy_0 = 16'h0001;
        ticks(12);
        chk("p1_lr_clash", 32'(bus.joystick1), 32'h1F);
        bus.joy_0 = 16'h0000;
        ticks(9);
        chk("p1_left_only", 32'(bus.joystick1), 32'h1D);
        kbd_event(1'b0, 8'h6B);
        ticks(10);
        chk("p1_left_rel", 32'(bus.joystick1), 32'h1F);

        bus.joy_1 = 16'h000C;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("p2_ud_clash", 32'(bus.joystick2), 32'h1F);
        end
        bus.joy_1 = 16'h0008;
        ticks(8);
        chk("p2_up_early", 32'(bus.joystick2), 32'h1F);
        tick();
        chk("p2_up", 32'(bus.joystick2), 32'h17);
        bus.joy_1 = 16'h0000;
        ticks(10);
        chk("p2_idle", 32'(bus.joystick2), 32'h1F);

        coin_run(0, fall_t, rise_t);
        chk("coin_fall", 32'(fall_t), 32'd9);
        chk("coin_width", 32'(rise_t - fall_t), 32'd100);
        ticks(5);
        coin_run(40, fall_t, rise_t);
        chk("coin2_fall", 32'(fall_t), 32'd9);
        chk("coin2_width", 32'(rise_t - fall_t), 32'd140);
        bus.joy_0 = 16'h0000;
        ticks(5);

        bus.joy_0 = 16'h0200;
        ticks(8);
        chk("pause1_early", 32'(bus.pause), 32'h0);
        tick();
        chk("pause1", 32'(bus.pause), 32'h1);
        bus.joy_0 = 16'h0000;
        ticks(12);
        chk("pause1_hold", 32'(bus.pause), 32'h1);
        bus.joy_0 = 16'h0200;
        ticks(9);
        chk("pause2", 32'(bus.pause), 32'h0);
        bus.joy_0 = 16'h0000;
        ticks(12);
        bus.pause_clr = 1'b1;
        bus.joy_0 = 16'h0200;
        ticks(12);
        chk("pause_clr_prio", 32'(bus.pause), 32'h0);
        bus.pause_clr = 1'b0;
        bus.joy_0 = 16'h0000;
        ticks(12);
        bus.joy_0 = 16'h0200;
        ticks(12);
        chk("pause4", 32'(bus.pause), 32'h1);
        bus.joy_0 = 16'h0000;
        ticks(12);
        bus.pause_clr = 1'b1;
        tick();
        chk("pause_clr", 32'(bus.pause), 32'h0);
        bus.pause_clr = 1'b0;

        // asynchronous reset mid coin pulse, with up held across reset
        bus.joy_0 = 16'h0100;
        ticks(9);
        chk("coin_pre_rst", 32'(bus.coin_input), 32'h0);
        bus.joy_0 = 16'h0000;
        ticks(20);
        chk("coin_mid", 32'(bus.coin_input), 32'h0);
        #2;
        rst_n = 1'b0;
        bus.joy_0 = 16'h0008;
        #1;
        chk("coin_async_rst", 32'(bus.coin_input), 32'h1);
        chk("async_rst_outs", 32'(outs()), 32'(IDLE));
        ticks(2);
        rst_n = 1'b1;
        ticks(8);
        chk("held_up_early", 32'(bus.joystick1), 32'h1F);
        tick();
        chk("held_up_again", 32'(bus.joystick1), 32'h17);
        chk("coin_after_rst", 32'(bus.coin_input), 32'h1);
        bus.joy_0 = 16'h0000;
        ticks(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
